// File: rtl/approx_line_cache_pkg.sv
// Shared types, geometry constants and line/word helpers for the approximate line cache.
package approx_line_cache_pkg;

    localparam int ADDR_W       = 32;
    localparam int WORD_W       = 32;
    localparam int TAG_W        = 25;
    localparam int IDX_W        = 4;
    localparam int OFF_W        = 3;
    localparam int NUM_LINES    = 16;
    localparam int WORDS_PER_LN = 8;
    localparam int LINE_W       = 256;
    localparam int CNT_W        = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        MEM_WR,
        RESP
    } state_e;

    // Word 0 sits in the most significant bits of the line.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        return line[(LINE_W-1) - WORD_W*int'(off) -: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] res;
        res = line;
        res[(LINE_W-1) - WORD_W*int'(off) -: WORD_W] = word;
        return res;
    endfunction

    function automatic logic [LINE_W-1:0] approx_line(input logic [LINE_W-1:0] line,
                                                      input logic [2:0]        bits);
        logic [7:0]        mask;
        logic [LINE_W-1:0] res;
        mask = 8'hFF << bits;
        for (int b = 0; b < LINE_W/8; b++) begin
            res[8*b +: 8] = line[8*b +: 8] & mask;
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/approx_line_cache_if.sv
// CPU-side request/response and MainMemory signals of the approximate line cache.
interface approx_line_cache_if;
    import approx_line_cache_pkg::*;

    logic                 cpu_valid;
    logic                 cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [WORD_W-1:0]    cpu_wdata;
    logic                 approx_en;
    logic                 cpu_ready;
    logic [WORD_W-1:0]    cpu_rdata;

    logic                 mem_valid;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_sent;
    logic [LINE_W-1:0]    mem_line;
    logic [TAG_W-1:0]     mem_tag;
    logic                 mem_wr_en;
    logic [WORD_W-1:0]    mem_wdata;

    logic [CNT_W-1:0]     hit_cnt;
    logic [CNT_W-1:0]     miss_cnt;
    logic                 tag_err;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, approx_en,
        input  mem_sent, mem_line, mem_tag,
        output cpu_ready, cpu_rdata,
        output mem_valid, mem_addr, mem_wr_en, mem_wdata,
        output hit_cnt, miss_cnt, tag_err
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, approx_en,
        output mem_sent, mem_line, mem_tag,
        input  cpu_ready, cpu_rdata,
        input  mem_valid, mem_addr, mem_wr_en, mem_wdata,
        input  hit_cnt, miss_cnt, tag_err
    );

endinterface

// File: rtl/approx_line_cache_line_store.sv
// Valid/tag/data arrays: one combinational read port, one line-write port, one word-write port.
module approx_line_cache_line_store
    import approx_line_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic                 o_rd_valid,
    output logic [TAG_W-1:0]     o_rd_tag,
    output logic [LINE_W-1:0]    o_rd_line,
    input  logic                 i_line_we,
    input  logic [IDX_W-1:0]     i_line_idx,
    input  logic [TAG_W-1:0]     i_line_tag,
    input  logic [LINE_W-1:0]    i_line_data,
    input  logic                 i_word_we,
    input  logic [IDX_W-1:0]     i_word_idx,
    input  logic [OFF_W-1:0]     i_word_off,
    input  logic [WORD_W-1:0]    i_word_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_line_we) begin
            r_valid[i_line_idx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_line_idx]  <= i_line_tag;
            r_data[i_line_idx] <= i_line_data;
        end else if (i_word_we) begin
            r_data[i_word_idx] <= put_word(r_data[i_word_idx], i_word_off, i_word_data);
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/approx_line_cache.sv
// Direct-mapped write-through read cache with optional approximate (LSB-cleared) line fills.
module approx_line_cache
    import approx_line_cache_pkg::*;
#(
    parameter int APPROX_BITS = 2
)(
    input  logic               clk,
    input  logic               rst,
    approx_line_cache_if.slave bus
);

    localparam logic [2:0] FILL_BITS = 3'(APPROX_BITS);

    state_e               r_state;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [WORD_W-1:0]    r_wdata;
    logic [LINE_W-1:0]    r_line;
    logic [TAG_W-1:0]     r_mem_tag;

    logic                 r_cpu_ready;
    logic [WORD_W-1:0]    r_cpu_rdata;
    logic                 r_mem_valid;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_wr_en;
    logic [WORD_W-1:0]    r_mem_wdata;
    logic [CNT_W-1:0]     r_hit_cnt;
    logic [CNT_W-1:0]     r_miss_cnt;
    logic                 r_tag_err;

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [OFF_W-1:0]     w_off;
    logic                 w_rd_valid;
    logic [TAG_W-1:0]     w_rd_tag;
    logic [LINE_W-1:0]    w_rd_line;
    logic                 w_hit;
    logic [2:0]           w_bits;
    logic [LINE_W-1:0]    w_fill_line;
    logic                 w_line_we;
    logic                 w_word_we;

    assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx       = r_addr[OFF_W +: IDX_W];
    assign w_off       = r_addr[OFF_W-1:0];
    assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
    assign w_bits      = bus.approx_en ? FILL_BITS : 3'd0;
    assign w_fill_line = approx_line(r_line, w_bits);
    assign w_line_we   = (r_state == FILL);
    assign w_word_we   = (r_state == LOOKUP) && r_we && w_hit;

    approx_line_cache_line_store u_store (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_idx),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_line   (w_rd_line),
        .i_line_we   (w_line_we),
        .i_line_idx  (w_idx),
        .i_line_tag  (w_tag),
        .i_line_data (w_fill_line),
        .i_word_we   (w_word_we),
        .i_word_idx  (w_idx),
        .i_word_off  (w_off),
        .i_word_data (r_wdata)
    );

    // Request and returned-line capture; only meaningful once the FSM has accepted them.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && bus.cpu_valid) begin
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
        end
        if (r_state == MEM_WAIT && bus.mem_sent) begin
            r_line    <= bus.mem_line;
            r_mem_tag <= bus.mem_tag;
        end
    end

    // Pulse outputs are raised on the transition into their state so they are high in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wr_en <= 1'b0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_tag_err   <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cpu_valid) begin
                        r_we    <= bus.cpu_we;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (r_we) begin
                        r_mem_wr_en <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= MEM_WR;
                    end else if (w_hit) begin
                        r_cpu_rdata <= line_word(w_rd_line, w_off);
                        r_hit_cnt   <= sat_inc(r_hit_cnt);
                        r_cpu_ready <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_miss_cnt  <= sat_inc(r_miss_cnt);
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_state     <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    r_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (bus.mem_sent) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (r_mem_tag != w_tag) begin
                        r_tag_err <= 1'b1;
                    end
                    r_cpu_rdata <= line_word(w_fill_line, w_off);
                    r_cpu_ready <= 1'b1;
                    r_state     <= RESP;
                end
                MEM_WR: begin
                    r_cpu_ready <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr_en = r_mem_wr_en;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.miss_cnt  = r_miss_cnt;
    assign bus.tag_err   = r_tag_err;

endmodule

// File: tb/tb_approx_line_cache.sv
// Randomized scoreboard bench for approx_line_cache with a word-level cache/memory reference model.
module tb_approx_line_cache;
    import approx_line_cache_pkg::*;

    localparam int APPROX_BITS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    approx_line_cache_if bus();

    approx_line_cache #(.APPROX_BITS(APPROX_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
        int          lat;
        int          issue;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   resp_cnt = 0;
    int   resp_target = 0;
    int   n_mreq = 0;
    int   n_mwr = 0;

    // Reference model: cache contents as words, memory as preload rule plus written words.
    bit          m_valid [16];
    logic [24:0] m_tag   [16];
    logic [31:0] m_data  [16][8];
    logic [31:0] mem_w   [logic [31:0]];
    int          exp_hit = 0;
    int          exp_miss = 0;
    int          exp_mreq = 0;
    int          exp_mwr = 0;
    bit          exp_tag_err = 0;

    int          cur_delay = 1;
    bit          cur_corrupt = 0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    bit          stray_ok = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        longint unsigned base;
        logic [31:0]     w;
        if (mem_w.exists(a)) return mem_w[a];
        base = longint'(a) * 4;
        for (int k = 0; k < 4; k++) w[31-8*k -: 8] = 8'((base + longint'(k)) % 10);
        return w;
    endfunction

    function automatic logic [31:0] approx_word(input logic [31:0] w, input int bits);
        logic [31:0] r;
        logic [7:0]  b;
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            b = (b >> bits) << bits;
            r[8*k +: 8] = b;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        exp_hit     = 0;
        exp_miss    = 0;
        exp_tag_err = 0;
    endtask

    task automatic do_reset();
        bus.cpu_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        q.delete();
        resp_target = resp_cnt;
    endtask

    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit approx, output int t);
        @(posedge clk);
        #1;
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.approx_en = approx;
        t = cyc;
        @(posedge clk);
        #1;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit approx, input int delay, input bit corrupt);
        int          idx, off, t, lat;
        logic [24:0] tag;
        logic [31:0] rd;
        bit          hit;
        idx = int'(addr[6:3]);
        off = int'(addr[2:0]);
        tag = addr[31:7];
        hit = m_valid[idx] && (m_tag[idx] == tag);
        cur_addr    = addr;
        cur_wdata   = wdata;
        cur_delay   = delay;
        cur_corrupt = corrupt;
        rd = '0;
        if (we) begin
            lat = 3;
            mem_w[addr] = wdata;
            if (hit) m_data[idx][off] = wdata;
            exp_mwr++;
        end else if (hit) begin
            lat = 2;
            rd = m_data[idx][off];
            exp_hit++;
        end else begin
            lat = 4 + delay;
            exp_miss++;
            exp_mreq++;
            for (int w = 0; w < 8; w++)
                m_data[idx][w] = approx_word(mem_word((addr & ~32'd7) + 32'(w)), approx ? APPROX_BITS : 0);
            m_tag[idx]   = tag;
            m_valid[idx] = 1;
            rd = m_data[idx][off];
            if (corrupt) exp_tag_err = 1;
        end
        issue(we, addr, wdata, approx, t);
        q.push_back('{we, rd, lat, t});
        resp_target++;
        for (int i = 0; i < 60 && resp_cnt < resp_target; i++) @(posedge clk);
        if (resp_cnt < resp_target) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no cpu_ready for addr %h within 60 cycles", addr);
            q.delete();
            resp_target = resp_cnt;
        end
        @(negedge clk);
        chk("hit_cnt", bus.hit_cnt, 32'(exp_hit));
        chk("miss_cnt", bus.miss_cnt, 32'(exp_miss));
        chk("tag_err", 32'(bus.tag_err), 32'(exp_tag_err));
        chk("mem_valid_pulses", 32'(n_mreq), 32'(exp_mreq));
        chk("mem_wr_en_pulses", 32'(n_mwr), 32'(exp_mwr));
        bus.approx_en = 1'($urandom);
    endtask

    // MainMemory responder: answers each mem_valid after cur_delay cycles; may emit stray strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_valid) begin
                for (int i = 1; i < cur_delay; i++) @(posedge clk);
                @(posedge clk);
                #1;
                for (int w = 0; w < 8; w++)
                    bus.mem_line[255-32*w -: 32] = mem_word((cur_addr & ~32'd7) + 32'(w));
                bus.mem_tag  = cur_addr[31:7] ^ 25'(cur_corrupt);
                bus.mem_sent = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_sent = 1'b0;
            end else if (stray_ok && $urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
                for (int w = 0; w < 8; w++) bus.mem_line[32*w +: 32] = $urandom;
                bus.mem_tag  = 25'($urandom);
                bus.mem_sent = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_sent = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every cpu_ready and checks memory-side strobes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_valid) begin
                    n_mreq++;
                    chk("mem_req_addr", bus.mem_addr, cur_addr);
                end
                if (bus.mem_wr_en) begin
                    n_mwr++;
                    chk("mem_wr_addr", bus.mem_addr, cur_addr);
                    chk("mem_wdata", bus.mem_wdata, cur_wdata);
                end
                if (bus.mem_valid || bus.mem_wr_en)
                    chk("mem_exclusive", 32'(bus.mem_valid & bus.mem_wr_en), 32'd0);
                if (bus.cpu_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: cpu_ready=1 with nothing outstanding (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                        if (!e.we) chk("rdata", bus.cpu_rdata, e.rdata);
                    end
                    resp_cnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "global timeout");
    end

    initial begin
        int t;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.approx_en = 1'b0;
        bus.mem_sent  = 1'b0;
        bus.mem_line  = '0;
        bus.mem_tag   = '0;
        do_reset();

        @(negedge clk);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
        chk("rst_tag_err", 32'(bus.tag_err), 32'd0);

        // Cold miss, then hit on the same word.
        do_req(0, 32'h1, 0, 0, 1, 0);
        do_req(0, 32'h1, 0, 0, 1, 0);

        // Approximate fill after reset.
        do_reset();
        do_req(0, 32'h9, 0, 1, 1, 0);

        // Write hit followed by read-back, then a conflicting tag evicting the line.
        do_req(0, 32'h1, 0, 0, 2, 0);
        do_req(1, 32'h1, 32'hDEADBEEF, 0, 1, 0);
        do_req(0, 32'h1, 0, 0, 1, 0);
        do_req(0, 32'h81, 0, 0, 3, 0);
        do_req(0, 32'h1, 0, 0, 1, 0);
        do_req(1, 32'h0000_0345, 32'h1234_5678, 0, 1, 0);

        // Reset while waiting on MainMemory; the late strobe must be ignored.
        cur_addr    = 32'h0000_0105;
        cur_delay   = 8;
        cur_corrupt = 0;
        exp_mreq++;
        issue(0, 32'h0000_0105, 0, 0, t);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        q.delete();
        resp_target = resp_cnt;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("abort_hit_cnt", bus.hit_cnt, 32'd0);
        chk("abort_miss_cnt", bus.miss_cnt, 32'd0);
        chk("abort_mem_valid_pulses", 32'(n_mreq), 32'(exp_mreq));
        do_req(0, 32'h0000_0105, 0, 0, 1, 0);

        // Tag mismatch on the returned line.
        do_req(0, 32'h0000_0213, 0, 0, 2, 1);
        do_req(0, 32'h0000_0214, 0, 0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 3)) << 3) | 32'($urandom_range(0, 7));
            if (n % 5 == 0) begin
                @(posedge clk);
                #1 stray_ok = 1;
                repeat (3) @(posedge clk);
                #1 stray_ok = 0;
                repeat (2) @(posedge clk);
            end
            do_req($urandom_range(0, 3) == 0, a, $urandom, 1'($urandom), $urandom_range(1, 4),
                   $urandom_range(0, 15) == 0);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
